// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the operation, operand and result signals of alu_issue_ctrl.
//   master : producer of operations, supplier of the alu result, consumer of results
//   slave  : the issue controller itself
// count is sized from DEPTH so both ends agree on its width.
interface alu_issue_ctrl_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_A;
  logic [31:0]   in_B;
  logic          in_Cin;
  logic [2:0]    in_opcode;
  logic [31:0]   A;
  logic [31:0]   B;
  logic          Cin;
  logic [2:0]    opcode;
  logic [63:0]   out;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_data;
  logic [2:0]    res_opcode;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_A, in_B, in_Cin, in_opcode, out, res_ready,
    input  in_ready, A, B, Cin, opcode, res_valid, res_data, res_opcode, count
  );

  modport slave (
    input  in_valid, in_A, in_B, in_Cin, in_opcode, out, res_ready,
    output in_ready, A, B, Cin, opcode, res_valid, res_data, res_opcode, count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational alu.
// Operations are queued in a DEPTH-entry FIFO, popped one at a time into
// registered operands (A/B/Cin/opcode), given one cycle for the alu to
// settle, and the result is captured and held until res_ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.in_*   : operation handshake and payload
//   bus.A..    : registered operands driven to the alu; bus.out is its result
//   bus.res_*  : result handshake, captured result and its opcode
//   bus.count  : FIFO occupancy
module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_issue_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [2:0]  op;
  } op_t;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  op_t             mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  op_t             opr;
  state_t          state, state_nxt;
  logic            pop, push;
  logic            res_valid;
  logic [63:0]     res_data;
  logic [2:0]      res_opcode;

  // Ready comes from registered occupancy only, so it never depends on res_ready.
  assign bus.in_ready = (cnt < CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;

  // Next state and pop decision. Pops look only at the registered count,
  // so an entry being written on the same edge cannot be popped (no bypass).
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (cnt != '0) begin
        pop       = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: state_nxt = HOLD;
      HOLD: if (bus.res_ready) begin
        if (cnt != '0) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Storage array carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{bus.in_A, bus.in_B, bus.in_Cin, bus.in_opcode};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Pointer width equals log2(DEPTH), so increment wraps modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Operands change only on a pop; result captured at the end of ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opr        <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_opcode <= '0;
    end else begin
      if (pop) opr <= mem[rd_ptr];
      if (state == ISSUE) begin
        res_valid  <= 1'b1;
        res_data   <= bus.out;
        res_opcode <= opr.op;
      end else if (state == HOLD && bus.res_ready) begin
        res_valid  <= 1'b0;
      end
    end
  end

  assign bus.A          = opr.a;
  assign bus.B          = opr.b;
  assign bus.Cin        = opr.cin;
  assign bus.opcode     = opr.op;
  assign bus.res_valid  = res_valid;
  assign bus.res_data   = res_data;
  assign bus.res_opcode = res_opcode;
  assign bus.count      = cnt;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a queue-based reference model checked every cycle,
// an in-order result scoreboard, and directed vectors with literal expectations.
module tb_alu_issue_ctrl;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [2:0]  op;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.DEPTH(DEPTH)) bus();
  alu_issue_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Reference alu used both as the environment's alu and by the model.
  function automatic logic [63:0] alu_f(input op_t o);
    case (o.op)
      3'd0: alu_f = {32'h0, o.a} + {32'h0, o.b} + {63'h0, o.c};
      3'd1: alu_f = {32'h0, o.a} - {32'h0, o.b};
      3'd2: alu_f = {32'h0, o.a & o.b};
      3'd3: alu_f = {32'h0, o.a | o.b};
      3'd4: alu_f = {32'h0, o.a ^ o.b};
      3'd5: alu_f = {32'h0, o.a} * {32'h0, o.b};
      3'd6: alu_f = {32'h0, o.a} << o.b[4:0];
      default: alu_f = {o.b, o.a};
    endcase
  endfunction

  assign bus.out = alu_f(op_t'({bus.A, bus.B, bus.Cin, bus.opcode}));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mq: waiting operations; m_cur: operation on the alu operands;
  // m_phase: 0 nothing in flight, 1 operands settling, 2 result presented.
  op_t         mq[$];
  op_t         exp_all[$];
  op_t         m_cur = '0;
  int          m_phase = 0;
  logic        m_rv = 1'b0;
  logic [63:0] m_res = '0;
  logic [2:0]  m_resop = '0;
  int          cyc = 0;
  int          delivered = 0;
  int          max_cnt = 0;
  int          hs_cyc[$];
  int          hs_op[$];
  bit          m_pop;
  int          m_n;
  op_t         m_in;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_all.delete();
      m_cur = '0; m_phase = 0; m_rv = 1'b0; m_res = '0; m_resop = '0;
    end else begin
      cyc++;
      m_n   = mq.size();
      m_pop = 1'b0;
      m_in  = '{bus.in_A, bus.in_B, bus.in_Cin, bus.in_opcode};
      if (m_phase == 0) begin
        m_pop = (m_n > 0);
      end else if (m_phase == 1) begin
        m_rv = 1'b1; m_res = alu_f(m_cur); m_resop = m_cur.op; m_phase = 2;
      end else if (bus.res_ready) begin
        m_rv = 1'b0;
        if (m_n > 0) m_pop = 1'b1;
        else         m_phase = 0;
      end
      if (m_pop) begin
        m_cur = mq.pop_front();
        m_phase = 1;
      end
      if (bus.in_valid && m_n < DEPTH) begin
        mq.push_back(m_in);
        exp_all.push_back(m_in);
      end
    end
  end

  // Every-cycle compare plus in-order result scoreboard.
  op_t e;
  always @(negedge clk) begin
    chk("in_ready", {63'h0, bus.in_ready}, {63'h0, mq.size() < DEPTH});
    chk("count", 64'(bus.count), 64'(mq.size()));
    chk("res_valid", {63'h0, bus.res_valid}, {63'h0, m_rv});
    chk("res_data", bus.res_data, m_res);
    chk("res_opcode", 64'(bus.res_opcode), 64'(m_resop));
    chk("operands", {bus.A, bus.B, bus.Cin, bus.opcode}, m_cur);
    if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    if (bus.res_valid && bus.res_ready) begin
      if (exp_all.size() == 0) begin
        chk("unexpected_result", 64'(bus.res_opcode), 64'hFFFF);
      end else begin
        e = exp_all.pop_front();
        chk("order_data", bus.res_data, alu_f(e));
        chk("order_opcode", 64'(bus.res_opcode), 64'(e.op));
        delivered++;
        hs_cyc.push_back(cyc);
        hs_op.push_back(int'(bus.res_opcode));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic [2:0] op);
    bus.in_valid = v; bus.in_A = a; bus.in_B = b; bus.in_Cin = c; bus.in_opcode = op;
  endtask

  // Caller positions time just after an edge (or at a reset release);
  // the next rising edge is edge N.
  task automatic single_op();
    drive(1'b1, 32'hFA912345, 32'hABCD1234, 1'b1, 3'b000);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("single_count_N", 64'(bus.count), 64'd1);
    @(negedge clk);
    chk("single_A_N1", 64'(bus.A), 64'hFA912345);
    chk("single_B_N1", 64'(bus.B), 64'hABCD1234);
    chk("single_Cin_N1", 64'(bus.Cin), 64'd1);
    chk("single_rv_N1", 64'(bus.res_valid), 64'd0);
    @(negedge clk);
    chk("single_rv_N2", 64'(bus.res_valid), 64'd1);
    chk("single_data_N2", bus.res_data, 64'h0000_0001_A65E_357A);
    chk("single_op_N2", 64'(bus.res_opcode), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int  acc;
  bit  rdy;
  logic [63:0] held;

  initial begin
    drive(1'b0, '0, '0, 1'b0, '0);
    bus.res_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_A", 64'(bus.A), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single operation latency.
    single_op();

    // Fill with results stalled: one op goes onto the operands, four queue.
    bus.res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h1000 + k, k * 3, k[0], 3'(k));
      @(posedge clk); #1;
    end
    drive(1'b1, 32'h1005, 32'd15, 1'b1, 3'd5);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("fill_count", 64'(bus.count), 64'd4);
      chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
      chk("fill_held_valid", 64'(bus.res_valid), 64'd1);
      chk("fill_held_data", bus.res_data, 64'h1000);
      chk("fill_held_op", 64'(bus.res_opcode), 64'd0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    // Drain in order at 2-cycle spacing.
    hs_cyc.delete(); hs_op.delete();
    bus.res_ready = 1'b1;
    for (int c = 0; c < 40 && !(bus.count == 0 && !bus.res_valid && hs_op.size() >= 5); c++)
      @(posedge clk);
    #1;
    chk("drain_n", 64'(hs_op.size()), 64'd5);
    for (int i = 0; i < hs_op.size() && i < 5; i++) begin
      chk("drain_op", 64'(hs_op[i]), 64'(i));
      if (i > 0) chk("drain_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd2);
    end
    @(negedge clk);
    chk("drain_count", 64'(bus.count), 64'd0);
    chk("drain_idle_rv", 64'(bus.res_valid), 64'd0);
    @(posedge clk); #1;

    // Random stream with wrap and simultaneous push/pop.
    delivered = 0; max_cnt = 0; acc = 0;
    for (int c = 0; c < 400 && acc < 12; c++) begin
      drive(1'($urandom_range(0, 1)), 32'h23456789, 32'hBCDEF123, 1'(acc), 3'(acc));
      bus.res_ready = 1'($urandom_range(0, 1));
      @(negedge clk); rdy = bus.in_ready;
      @(posedge clk);
      if (bus.in_valid && rdy) acc++;
      #1;
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 400 && delivered < 12; c++) begin
      bus.res_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    chk("stream_accepted", 64'(acc), 64'd12);
    chk("stream_delivered", 64'(delivered), 64'd12);
    chk("stream_max_count_ok", 64'(max_cnt <= DEPTH), 64'd1);
    repeat (3) @(posedge clk); #1;

    // Reset mid-stream: one op on the alu with its result held, three queued.
    bus.res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h77 + k, 32'h5, 1'b0, 3'(k + 1));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", 64'(bus.count), 64'd3);
    chk("pre_rst_rv", 64'(bus.res_valid), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_rv", 64'(bus.res_valid), 64'd0);
    chk("mid_rst_data", bus.res_data, 64'd0);
    chk("mid_rst_op", 64'(bus.res_opcode), 64'd0);
    chk("mid_rst_operands", {bus.A, bus.B, bus.Cin, bus.opcode}, 68'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    // First accept on the first rising edge after release.
    single_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
